// File: rtl/cnnip_mem_arbiter_if.sv
// rtl/cnnip_mem_arbiter_if.sv - request/grant/SRAM bundle for the two-requester SRAM arbiter
//
// Purpose: groups both requester ports and the single-port SRAM port.
// Ports (signals):
//   reqN_en/we/addr/din   requester -> arbiter access request and write data
//   reqN_gnt              arbiter -> requester, access accepted this cycle
//   reqN_dout/rvalid      arbiter -> requester, read data and its qualifier
//   mem_en/we/addr/din    arbiter -> SRAM command
//   mem_dout              SRAM -> arbiter read data
// Modports: slave = arbiter side, master = requesters plus SRAM model side.

interface cnnip_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int WE_W   = 4
);
  logic              req0_en;
  logic [WE_W-1:0]   req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_din;
  logic              req0_gnt;
  logic [DATA_W-1:0] req0_dout;
  logic              req0_rvalid;

  logic              req1_en;
  logic [WE_W-1:0]   req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_din;
  logic              req1_gnt;
  logic [DATA_W-1:0] req1_dout;
  logic              req1_rvalid;

  logic              mem_en;
  logic [WE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0_en, req0_we, req0_addr, req0_din,
    output req0_gnt, req0_dout, req0_rvalid,
    input  req1_en, req1_we, req1_addr, req1_din,
    output req1_gnt, req1_dout, req1_rvalid,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output req0_en, req0_we, req0_addr, req0_din,
    input  req0_gnt, req0_dout, req0_rvalid,
    output req1_en, req1_we, req1_addr, req1_din,
    input  req1_gnt, req1_dout, req1_rvalid,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/cnnip_mem_arbiter.sv
// rtl/cnnip_mem_arbiter.sv - round-robin arbiter sharing one single-port SRAM between two requesters
//
// Purpose: grants one SRAM access per cycle to requester 0 (CNN controller)
// or requester 1 (host/DMA), drives the SRAM port from the granted requester
// and tags read data back to its issuer after RD_LAT cycles.
// Ports:
//   clk_a     clock
//   arstz_aq  asynchronous active-low reset
//   bus       cnnip_mem_arbiter_if.slave (requester 0/1 ports, SRAM port)

module cnnip_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int WE_W   = 4,
  parameter int RD_LAT = 1
) (
  input  logic                   clk_a,
  input  logic                   arstz_aq,
  cnnip_mem_arbiter_if.slave     bus
);

  // Id of the last granted requester; on a tie the other one wins.
  logic              last_aq_q, last_aq_d;
  // Read-return pipeline: stage RD_LAT-1 lines up with mem_dout.
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0] rd_id_q, rd_id_d;

  logic              act0, act1;
  logic              gnt0, gnt1;
  logic              xfer;
  logic              gnt_id;
  logic [WE_W-1:0]   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  always_comb begin
    act0     = 1'b0;
    act1     = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    xfer     = 1'b0;
    gnt_id   = 1'b0;
    sel_we   = '0;
    sel_addr = '0;
    sel_din  = '0;
    last_aq_d = last_aq_q;
    rd_vld_d  = '0;
    rd_id_d   = '0;

    // Requests are masked while reset is held so the SRAM port stays idle
    // even if a requester keeps its enable high through reset.
    act0 = bus.req0_en & arstz_aq;
    act1 = bus.req1_en & arstz_aq;
    gnt0 = act0 & (~act1 | last_aq_q);
    gnt1 = act1 & (~act0 | ~last_aq_q);
    xfer   = gnt0 | gnt1;
    gnt_id = gnt1;

    if (gnt0) begin
      sel_we   = bus.req0_we;
      sel_addr = bus.req0_addr;
      sel_din  = bus.req0_din;
    end else if (gnt1) begin
      sel_we   = bus.req1_we;
      sel_addr = bus.req1_addr;
      sel_din  = bus.req1_din;
    end

    if (xfer) begin
      last_aq_d = gnt_id;
    end

    rd_vld_d[0] = xfer & (sel_we == '0);
    rd_id_d[0]  = gnt_id;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_id_d[i]  = rd_id_q[i-1];
    end
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      last_aq_q <= 1'b1;
      rd_vld_q  <= '0;
      rd_id_q   <= '0;
    end else begin
      last_aq_q <= last_aq_d;
      rd_vld_q  <= rd_vld_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign bus.req0_gnt = gnt0;
  assign bus.req1_gnt = gnt1;

  assign bus.mem_en   = xfer;
  assign bus.mem_we   = sel_we;
  assign bus.mem_addr = sel_addr;
  assign bus.mem_din  = sel_din;

  // Read data fans out unregistered; only rvalid says whose it is.
  assign bus.req0_dout   = bus.mem_dout;
  assign bus.req1_dout   = bus.mem_dout;
  assign bus.req0_rvalid = rd_vld_q[RD_LAT-1] & ~rd_id_q[RD_LAT-1];
  assign bus.req1_rvalid = rd_vld_q[RD_LAT-1] &  rd_id_q[RD_LAT-1];

endmodule

// File: tb/tb_cnnip_mem_arbiter.sv
// tb/tb_cnnip_mem_arbiter.sv - directed table-driven bench for cnnip_mem_arbiter

module tb_cnnip_mem_arbiter;

  logic clk_a = 1'b0;
  logic arstz_aq = 1'b0;
  always #5 clk_a = ~clk_a;

  logic        r0_en, r1_en;
  logic [3:0]  r0_we, r1_we;
  logic [11:0] r0_addr, r1_addr;
  logic [31:0] r0_din, r1_din;
  logic [31:0] md1, md3;

  int n_vec  = 0;
  int n_fail = 0;

  cnnip_mem_arbiter_if #(.ADDR_W(12), .DATA_W(32), .WE_W(4)) bus1 ();
  cnnip_mem_arbiter_if #(.ADDR_W(12), .DATA_W(32), .WE_W(4)) bus3 ();

  assign bus1.req0_en = r0_en;   assign bus3.req0_en = r0_en;
  assign bus1.req0_we = r0_we;   assign bus3.req0_we = r0_we;
  assign bus1.req0_addr = r0_addr; assign bus3.req0_addr = r0_addr;
  assign bus1.req0_din = r0_din; assign bus3.req0_din = r0_din;
  assign bus1.req1_en = r1_en;   assign bus3.req1_en = r1_en;
  assign bus1.req1_we = r1_we;   assign bus3.req1_we = r1_we;
  assign bus1.req1_addr = r1_addr; assign bus3.req1_addr = r1_addr;
  assign bus1.req1_din = r1_din; assign bus3.req1_din = r1_din;
  assign bus1.mem_dout = md1;
  assign bus3.mem_dout = md3;

  cnnip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .WE_W(4), .RD_LAT(1)) dut1 (
    .clk_a(clk_a), .arstz_aq(arstz_aq), .bus(bus1)
  );
  cnnip_mem_arbiter #(.ADDR_W(12), .DATA_W(32), .WE_W(4), .RD_LAT(3)) dut3 (
    .clk_a(clk_a), .arstz_aq(arstz_aq), .bus(bus3)
  );

  typedef struct {
    logic        e0; logic [3:0] w0; logic [11:0] a0; logic [31:0] d0;
    logic        e1; logic [3:0] w1; logic [11:0] a1; logic [31:0] d1;
    logic [31:0] md;
    logic        g0, g1, men; logic [3:0] mwe; logic [11:0] maddr; logic [31:0] mdin;
    logic        rv0, rv1;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    r0_en = 0; r0_we = 0; r0_addr = 0; r0_din = 0;
    r1_en = 0; r1_we = 0; r1_addr = 0; r1_din = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk_a);
    #1;
  endtask

  task automatic reset_pulse();
    idle();
    arstz_aq = 1'b0;
    next_cycle();
    arstz_aq = 1'b1;
  endtask

  task automatic chk_idle_port(input string tag, input int which);
    if (which == 1) begin
      chk({tag, " gnt0"}, bus1.req0_gnt, 0);
      chk({tag, " gnt1"}, bus1.req1_gnt, 0);
      chk({tag, " mem_en"}, bus1.mem_en, 0);
      chk({tag, " mem_we"}, bus1.mem_we, 0);
      chk({tag, " mem_addr"}, bus1.mem_addr, 0);
      chk({tag, " mem_din"}, bus1.mem_din, 0);
      chk({tag, " rv0"}, bus1.req0_rvalid, 0);
      chk({tag, " rv1"}, bus1.req1_rvalid, 0);
    end else begin
      chk({tag, " gnt0"}, bus3.req0_gnt, 0);
      chk({tag, " gnt1"}, bus3.req1_gnt, 0);
      chk({tag, " mem_en"}, bus3.mem_en, 0);
      chk({tag, " mem_addr"}, bus3.mem_addr, 0);
      chk({tag, " rv0"}, bus3.req0_rvalid, 0);
      chk({tag, " rv1"}, bus3.req1_rvalid, 0);
    end
  endtask

  initial begin
    // RD_LAT=1 sequence starting from reset (last=1, pipeline empty).
    //          e0 w0  a0      d0      e1 w1    a1      d1            md          g0 g1 men mwe  maddr   mdin          rv0 rv1
    tbl[0]  = '{1, 0, 'h100, 0,       1, 'hF, 'h200, 'h11111111, 'hA0,       1, 0, 1, 'h0, 'h100, 0,           0, 0};
    tbl[1]  = '{1, 0, 'h100, 0,       1, 'hF, 'h200, 'h11111111, 'hA1,       0, 1, 1, 'hF, 'h200, 'h11111111,  1, 0};
    tbl[2]  = '{1, 0, 'h100, 0,       1, 'hF, 'h200, 'h11111111, 'hA2,       1, 0, 1, 'h0, 'h100, 0,           0, 0};
    tbl[3]  = '{1, 0, 'h100, 0,       1, 'hF, 'h200, 'h11111111, 'hA3,       0, 1, 1, 'hF, 'h200, 'h11111111,  1, 0};
    tbl[4]  = '{1, 0, 'h100, 0,       1, 'hF, 'h200, 'h11111111, 'hA4,       1, 0, 1, 'h0, 'h100, 0,           0, 0};
    tbl[5]  = '{1, 0, 'h100, 0,       1, 'hF, 'h200, 'h11111111, 'hA5,       0, 1, 1, 'hF, 'h200, 'h11111111,  1, 0};
    tbl[6]  = '{0, 0, 0,     0,       1, 'h3, 'h020, 'h5555,     'hA6,       0, 1, 1, 'h3, 'h020, 'h5555,      0, 0};
    tbl[7]  = '{1, 0, 'h020, 'h77,    0, 0,   0,     0,          'hA7,       1, 0, 1, 'h0, 'h020, 'h77,        0, 0};
    tbl[8]  = '{0, 0, 0,     0,       0, 0,   0,     0,          'hBEEF0008, 0, 0, 0, 'h0, 'h000, 0,           1, 0};
    tbl[9]  = '{0, 0, 0,     0,       1, 0,   'h033, 0,          'hA9,       0, 1, 1, 'h0, 'h033, 0,           0, 0};
    tbl[10] = '{1, 0, 'h044, 0,       1, 0,   'h055, 0,          'hAA,       1, 0, 1, 'h0, 'h044, 0,           0, 1};
    tbl[11] = '{1, 0, 'h045, 0,       1, 0,   'h055, 0,          'hAB,       0, 1, 1, 'h0, 'h055, 0,           1, 0};
    tbl[12] = '{0, 0, 0,     0,       0, 0,   0,     0,          'hAC,       0, 0, 0, 'h0, 'h000, 0,           0, 1};
    tbl[13] = '{0, 0, 0,     0,       0, 0,   0,     0,          'hAD,       0, 0, 0, 'h0, 'h000, 0,           0, 0};

    idle();
    md1 = 0; md3 = 0;

    // Reset held with a pending request: nothing may reach the SRAM.
    r0_en = 1; r0_addr = 'h010;
    next_cycle();
    next_cycle();
    @(negedge clk_a);
    chk_idle_port("rst1", 1);
    chk_idle_port("rst3", 3);

    // Release: request granted in the same cycle, then a single read returns.
    next_cycle();
    arstz_aq = 1'b1;
    @(negedge clk_a);
    chk("rel gnt0", bus1.req0_gnt, 1);
    chk("rel gnt1", bus1.req1_gnt, 0);
    chk("rel mem_en", bus1.mem_en, 1);
    chk("rel mem_addr", bus1.mem_addr, 'h010);
    chk("rel mem_we", bus1.mem_we, 0);
    next_cycle();
    r0_en = 0;
    md1 = 32'hDEADBEEF;
    @(negedge clk_a);
    chk("rd rv0", bus1.req0_rvalid, 1);
    chk("rd dout0", bus1.req0_dout, 32'hDEADBEEF);
    chk("rd rv1", bus1.req1_rvalid, 0);
    chk("rd mem_en", bus1.mem_en, 0);
    next_cycle();

    // Table: contention, mixed write/read, ties with rotating priority.
    reset_pulse();
    for (int i = 0; i < 14; i++) begin
      r0_en = tbl[i].e0; r0_we = tbl[i].w0; r0_addr = tbl[i].a0; r0_din = tbl[i].d0;
      r1_en = tbl[i].e1; r1_we = tbl[i].w1; r1_addr = tbl[i].a1; r1_din = tbl[i].d1;
      md1 = tbl[i].md;
      @(negedge clk_a);
      chk($sformatf("v%0d gnt0", i), bus1.req0_gnt, tbl[i].g0);
      chk($sformatf("v%0d gnt1", i), bus1.req1_gnt, tbl[i].g1);
      chk($sformatf("v%0d mem_en", i), bus1.mem_en, tbl[i].men);
      chk($sformatf("v%0d mem_we", i), bus1.mem_we, tbl[i].mwe);
      chk($sformatf("v%0d mem_addr", i), bus1.mem_addr, tbl[i].maddr);
      chk($sformatf("v%0d mem_din", i), bus1.mem_din, tbl[i].mdin);
      chk($sformatf("v%0d rv0", i), bus1.req0_rvalid, tbl[i].rv0);
      chk($sformatf("v%0d rv1", i), bus1.req1_rvalid, tbl[i].rv1);
      if (tbl[i].rv0) chk($sformatf("v%0d dout0", i), bus1.req0_dout, tbl[i].md);
      if (tbl[i].rv1) chk($sformatf("v%0d dout1", i), bus1.req1_dout, tbl[i].md);
      next_cycle();
    end

    // RD_LAT=3: reads 0,1,0 on cycles 0..2 return on cycles 3..5.
    reset_pulse();
    begin
      int e0s[7]  = '{1, 0, 1, 0, 0, 0, 0};
      int e1s[7]  = '{0, 1, 0, 0, 0, 0, 0};
      int rv0s[7] = '{0, 0, 0, 1, 0, 1, 0};
      int rv1s[7] = '{0, 0, 0, 0, 1, 0, 0};
      for (int k = 0; k < 7; k++) begin
        idle();
        r0_en = e0s[k][0]; r0_addr = 12'(k + 1);
        r1_en = e1s[k][0]; r1_addr = 12'(k + 1);
        md3 = 32'hD0 + k;
        @(negedge clk_a);
        chk($sformatf("lat%0d gnt0", k), bus3.req0_gnt, e0s[k]);
        chk($sformatf("lat%0d gnt1", k), bus3.req1_gnt, e1s[k]);
        chk($sformatf("lat%0d rv0", k), bus3.req0_rvalid, rv0s[k]);
        chk($sformatf("lat%0d rv1", k), bus3.req1_rvalid, rv1s[k]);
        if (k >= 3 && k <= 5) chk($sformatf("lat%0d dout", k), bus3.req0_dout, 32'hD0 + k);
        next_cycle();
      end
    end

    // Reset while a read is in flight: it must never return, and the
    // priority pointer goes back to favouring requester 0.
    reset_pulse();
    idle();
    r0_en = 1; r0_addr = 'h0AB;
    @(negedge clk_a);
    chk("mid gnt0 d1", bus1.req0_gnt, 1);
    chk("mid gnt0 d3", bus3.req0_gnt, 1);
    @(posedge clk_a);
    #1;
    idle();
    #1 arstz_aq = 1'b0;
    #1 arstz_aq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_a);
      chk($sformatf("mid%0d rv0 d1", k), bus1.req0_rvalid, 0);
      chk($sformatf("mid%0d rv0 d3", k), bus3.req0_rvalid, 0);
      chk($sformatf("mid%0d rv1 d3", k), bus3.req1_rvalid, 0);
      next_cycle();
    end
    r0_en = 1; r0_addr = 'h001;
    r1_en = 1; r1_addr = 'h002;
    @(negedge clk_a);
    chk("tie gnt0 d1", bus1.req0_gnt, 1);
    chk("tie gnt1 d1", bus1.req1_gnt, 0);
    chk("tie gnt0 d3", bus3.req0_gnt, 1);
    chk("tie gnt1 d3", bus3.req1_gnt, 0);
    next_cycle();
    idle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
